eth_phy_10g_rx_prbs_test_ctrl: RTL and testbench
================================================

// Module: eth_phy_10g_rx_prbs_test_ctrl
// PURPOSE
//  Sequences a PRBS31 bit-error-rate test on the 10GBASE-R RX PHY interface.
//  - Drives rx_prbs31_enable.
//  - Discards a settle interval, then accumulates the per-cycle 7-bit rx_error_count over a programmed window.
//  - Reports total errors and pass/fail against a threshold.
//  Sits beside the RX PHY IF; driven by a register block or test sequencer.
// PARAMETERS
//  SETTLE_CYCLES    16   cycles discarded after enable; covers checker LFSR seeding and error-count pipeline (min 4)
//  WINDOW_WIDTH     32   width of window_len and the measure cycle counter
//  ERR_COUNT_WIDTH  32   width of err_total and err_threshold
// PORTS
//  clk               in   1                clock (RX PHY clock domain)
//  rst               in   1                reset, asynchronous, active-high
//  start             in   1                pulse: begin a test (ignored while busy)
//  abort             in   1                level/pulse: terminate test immediately
//  window_len        in   WINDOW_WIDTH     measure window in cycles; latched on accepted start
//  err_threshold     in   ERR_COUNT_WIDTH  max errors for pass; latched on accepted start
//  rx_error_count    in   7                per-cycle error count from RX PHY IF
//  rx_prbs31_enable  out  1                PRBS31 checker enable to RX PHY IF
//  busy              out  1                high in SETTLE or MEASURE
//  done              out  1                one-cycle pulse on normal completion
//  pass              out  1                err_total <= threshold; valid from done until next start
//  err_total         out  ERR_COUNT_WIDTH  accumulated errors, saturating
//  err_sat           out  1                err_total saturated in current/last test
// BEHAVIOUR
//  Reset values (async assert): state=IDLE, all outputs 0, err_total=0.
//  States: IDLE, SETTLE, MEASURE; all outputs registered.
//  IDLE
//   - start & !abort -> SETTLE next edge.
//   - Latch window_len (0 treated as 1) and err_threshold.
//   - Clear err_total, err_sat, pass; load settle counter with SETTLE_CYCLES-1.
//  SETTLE
//   - rx_prbs31_enable=1, busy=1.
//   - Count down; at 0 -> MEASURE, load window counter with window_len-1.
//   - Exactly SETTLE_CYCLES cycles spent in SETTLE; rx_error_count ignored.
//  MEASURE
//   - rx_prbs31_enable=1, busy=1.
//   - Each cycle err_total <= sat(err_total + rx_error_count); sample count is exactly window_len.
//   - Saturation: if the sum exceeds all-ones, hold all-ones and set err_sat (sticky until next start).
//   - Window counter at 0: -> IDLE on the same edge that adds the last sample.
//   - On that edge: done=1 for one cycle, pass = (final err_total <= latched threshold).
//   - rx_prbs31_enable and busy drop on that edge.
//  Timing
//   - rx_prbs31_enable and busy rise on the edge after start is sampled.
//   - done rises SETTLE_CYCLES + window_len cycles after that edge.
//  Abort
//   - Abort in SETTLE/MEASURE -> IDLE next edge; rx_prbs31_enable=0, busy=0.
//   - No done pulse; pass=0; err_total and err_sat hold their partial values.
//   - The MEASURE sample on the abort edge is not added.
//  Other boundaries
//   - start while busy: ignored.
//   - start & abort in same IDLE cycle: abort wins, stay IDLE, nothing cleared.
//   - start on the cycle after done: accepted; clears results.
//   - Async rst mid-test: immediate return to reset values.
//  Arithmetic: rx_error_count zero-extended to ERR_COUNT_WIDTH+1 before add; compare unsigned.
// TESTING
//  1. SETTLE_CYCLES=16, window_len=100, threshold=0, rx_error_count=0 -> enable high 116 cycles; done 116 cycles after enable rise; err_total=0; pass=1.
//  2. window_len=10, threshold=25, rx_error_count=3 every cycle (including during settle) -> err_total=30 (settle ignored); pass=0; err_sat=0.
//  3. ERR_COUNT_WIDTH=8, window_len=5, rx_error_count=127 -> err_total=255; err_sat=1; pass=0 with threshold=200.
//  4. abort 5 cycles into MEASURE, rx_error_count=1 -> no done; enable low next edge; err_total=5; pass=0; busy=0.
//  5. start pulsed during MEASURE, then start+abort together in IDLE -> first ignored (done timing unchanged); second leaves IDLE, results intact.
//  6. window_len=0 -> behaves as 1 (one sample added); async rst during SETTLE -> all outputs 0 with no clock edge.

Source files
------------

// File: rtl/eth_phy_10g_rx_prbs_test_ctrl.sv
// ---------------------------------------------------------------------------
// eth_phy_10g_rx_prbs_test_ctrl
//
// Sequences a PRBS31 bit-error-rate test on the 10GBASE-R RX PHY interface.
// A test enables the RX PRBS31 checker, discards a settle interval while the
// checker LFSR seeds and the error-count pipeline fills, then accumulates the
// per-cycle error count over a programmed window. The saturating total and a
// pass/fail verdict against a threshold are reported at completion.
//
// Parameters
//   SETTLE_CYCLES    cycles discarded after enable (minimum 4)
//   WINDOW_WIDTH     width of window_len and the measure cycle counter
//   ERR_COUNT_WIDTH  width of err_total and err_threshold (at least 7)
//
// Ports
//   clk               in   RX PHY clock
//   rst               in   asynchronous, active-high reset
//   start             in   pulse: begin a test (ignored while busy)
//   abort             in   terminate a running test immediately
//   window_len        in   measure window in cycles (0 behaves as 1)
//   err_threshold     in   maximum error total that still passes
//   rx_error_count    in   per-cycle error count from the RX PHY IF
//   rx_prbs31_enable  out  PRBS31 checker enable to the RX PHY IF
//   busy              out  test in progress (settle or measure)
//   done              out  one-cycle pulse on normal completion
//   pass              out  err_total <= threshold; valid from done to next start
//   err_total         out  accumulated errors, saturating
//   err_sat           out  err_total saturated in the current/last test
// ---------------------------------------------------------------------------
module eth_phy_10g_rx_prbs_test_ctrl #(
    parameter int unsigned SETTLE_CYCLES   = 16,
    parameter int unsigned WINDOW_WIDTH    = 32,
    parameter int unsigned ERR_COUNT_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       abort,
    input  logic [WINDOW_WIDTH-1:0]    window_len,
    input  logic [ERR_COUNT_WIDTH-1:0] err_threshold,
    input  logic [6:0]                 rx_error_count,
    output logic                       rx_prbs31_enable,
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
    output logic [ERR_COUNT_WIDTH-1:0] err_total,
    output logic                       err_sat
);

    localparam int unsigned SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_MEASURE = 2'd2
    } state_e;

    state_e                     state_q,      state_d;
    logic [SETTLE_W-1:0]        settle_cnt_q, settle_cnt_d;
    logic [WINDOW_WIDTH-1:0]    win_len_q,    win_len_d;
    logic [WINDOW_WIDTH-1:0]    win_cnt_q,    win_cnt_d;
    logic [ERR_COUNT_WIDTH-1:0] thr_q,        thr_d;
    logic [ERR_COUNT_WIDTH-1:0] err_total_q,  err_total_d;
    logic                       err_sat_q,    err_sat_d;
    logic                       pass_q,       pass_d;
    logic                       done_q,       done_d;
    logic                       enable_q,     enable_d;

    // One extra bit catches overflow of the running total.
    logic [ERR_COUNT_WIDTH:0]   sum;
    logic [ERR_COUNT_WIDTH-1:0] sum_sat;

    always_comb begin
        sum     = {1'b0, err_total_q} + (ERR_COUNT_WIDTH+1)'(rx_error_count);
        sum_sat = sum[ERR_COUNT_WIDTH] ? '1 : sum[ERR_COUNT_WIDTH-1:0];
    end

    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        win_len_d    = win_len_q;
        win_cnt_d    = win_cnt_q;
        thr_d        = thr_q;
        err_total_d  = err_total_q;
        err_sat_d    = err_sat_q;
        pass_d       = pass_q;
        done_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // abort wins over a simultaneous start; nothing is cleared then
                if (start && !abort) begin
                    state_d      = ST_SETTLE;
                    win_len_d    = (window_len == '0) ? WINDOW_WIDTH'(1) : window_len;
                    thr_d        = err_threshold;
                    err_total_d  = '0;
                    err_sat_d    = 1'b0;
                    pass_d       = 1'b0;
                    settle_cnt_d = SETTLE_LOAD;
                end
            end

            ST_SETTLE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    pass_d  = 1'b0;
                end else if (settle_cnt_q == '0) begin
                    state_d   = ST_MEASURE;
                    win_cnt_d = win_len_q - WINDOW_WIDTH'(1);
                end else begin
                    settle_cnt_d = settle_cnt_q - SETTLE_W'(1);
                end
            end

            ST_MEASURE: begin
                if (abort) begin
                    // sample present on the abort edge is dropped
                    state_d = ST_IDLE;
                    pass_d  = 1'b0;
                end else begin
                    err_total_d = sum_sat;
                    if (sum[ERR_COUNT_WIDTH]) begin
                        err_sat_d = 1'b1;
                    end
                    if (win_cnt_q == '0) begin
                        // last sample is added on the same edge that ends the test
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                        pass_d  = (sum_sat <= thr_q);
                    end else begin
                        win_cnt_d = win_cnt_q - WINDOW_WIDTH'(1);
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // enable/busy are registered copies of "next state is active"
        enable_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            settle_cnt_q <= '0;
            win_len_q    <= '0;
            win_cnt_q    <= '0;
            thr_q        <= '0;
            err_total_q  <= '0;
            err_sat_q    <= 1'b0;
            pass_q       <= 1'b0;
            done_q       <= 1'b0;
            enable_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            win_len_q    <= win_len_d;
            win_cnt_q    <= win_cnt_d;
            thr_q        <= thr_d;
            err_total_q  <= err_total_d;
            err_sat_q    <= err_sat_d;
            pass_q       <= pass_d;
            done_q       <= done_d;
            enable_q     <= enable_d;
        end
    end

    assign rx_prbs31_enable = enable_q;
    assign busy             = enable_q;
    assign done             = done_q;
    assign pass             = pass_q;
    assign err_total        = err_total_q;
    assign err_sat          = err_sat_q;

endmodule

// File: tb/tb_eth_phy_10g_rx_prbs_test_ctrl.sv
`timescale 1ns/1ps
module tb_eth_phy_10g_rx_prbs_test_ctrl;

    localparam int S    = 16;
    localparam int WW   = 16;
    localparam int EW   = 10;
    localparam int EMAX = (1 << EW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [WW-1:0] window_len = '0;
    logic [EW-1:0] err_threshold = '0;
    logic [6:0]    rx_error_count = '0;
    logic          rx_prbs31_enable, busy, done, pass, err_sat;
    logic [EW-1:0] err_total;

    eth_phy_10g_rx_prbs_test_ctrl #(
        .SETTLE_CYCLES  (S),
        .WINDOW_WIDTH   (WW),
        .ERR_COUNT_WIDTH(EW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .abort           (abort),
        .window_len      (window_len),
        .err_threshold   (err_threshold),
        .rx_error_count  (rx_error_count),
        .rx_prbs31_enable(rx_prbs31_enable),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .err_total       (err_total),
        .err_sat         (err_sat)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        bit chk_len;
        int len;
        bit done;
        int total;
        bit sat;
        bit pass;
    } exp_t;

    exp_t exp_q[$];
    int   last_total;
    bit   last_sat;
    bit   last_pass;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: one scoreboard entry is consumed each time a test ends (busy falls).
    bit busy_prev   = 1'b0;
    int busy_len    = 0;
    bit done_follow = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (done_follow) begin
            chk("done_one_cycle", done, 0);
            done_follow = 1'b0;
        end
        if (busy && !busy_prev) chk("enable_rise", rx_prbs31_enable, 1);
        if (busy) busy_len++;
        if (busy_prev && !busy) begin
            chk("enable_fall", rx_prbs31_enable, 0);
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_end: test ended with no expectation queued (t=%0t)", $time);
            end else begin
                e = exp_q.pop_front();
                if (e.chk_len) chk("busy_len", busy_len, e.len);
                chk("done", done, e.done);
                chk("err_total", err_total, e.total);
                chk("err_sat", err_sat, e.sat);
                chk("pass", pass, e.pass);
                if (done) done_follow = 1'b1;
            end
            busy_len = 0;
        end
        busy_prev = busy;
    end

    // Called at #1 after a posedge. k counts edges after the start-sampling edge E0;
    // the value driven after E_k is sampled at E_(k+1). Measure samples are those
    // driven for k in [S, S+weff), truncated before the abort (ka = abort driven after E_ka).
    task automatic run_test(input int w, input int thr, input int ka, input bit mid_start,
                            input int lo, input int hi);
        int weff;
        int end_e;
        int sum;
        int smid;
        int v;
        exp_t e;
        weff  = (w == 0) ? 1 : w;
        end_e = (ka >= 0) ? ka + 1 : S + weff;
        sum   = 0;
        smid  = -1;
        if (mid_start && end_e > 1) smid = $urandom_range(end_e - 1, 1);
        start          = 1'b1;
        abort          = 1'b0;
        window_len     = WW'(w);
        err_threshold  = EW'(thr);
        rx_error_count = 7'($urandom_range(hi, lo));
        for (int k = 0; k <= end_e; k++) begin
            @(posedge clk); #1;
            start = (k == smid);
            abort = (k == ka);
            if (k == 0) begin
                // latched values must not follow later input changes
                window_len    = WW'($urandom);
                err_threshold = EW'($urandom);
            end
            v = $urandom_range(hi, lo);
            rx_error_count = 7'(v);
            if (k >= S && k < S + weff && (ka < 0 || k < ka)) sum += v;
        end
        e.chk_len = 1'b1;
        e.len     = end_e;
        e.done    = (ka < 0);
        e.sat     = (sum > EMAX);
        e.total   = e.sat ? EMAX : sum;
        e.pass    = (ka < 0) && (e.total <= thr);
        exp_q.push_back(e);
        last_total = e.total;
        last_sat   = e.sat;
        last_pass  = e.pass;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_enable"}, rx_prbs31_enable, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_pass"}, pass, 0);
        chk({tag, "_err_total"}, err_total, 0);
        chk({tag, "_err_sat"}, err_sat, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        #2 rst = 1'b1;
        #2 check_all_zero("reset_async");
        repeat (3) @(posedge clk);
        #1 check_all_zero("reset_held");
        rst = 1'b0;
        idle_cycles(2);

        // window 100, no errors, threshold 0 -> 116 busy cycles, pass
        run_test(100, 0, -1, 1'b0, 0, 0);
        idle_cycles(1);
        // constant 3 errors incl. settle -> 30, fail against 25
        run_test(10, 25, -1, 1'b0, 3, 3);
        // back-to-back start in the done cycle; saturation
        run_test(10, 200, -1, 1'b0, 127, 127);
        // new start clears the sticky saturation flag
        run_test(4, 1023, -1, 1'b0, 2, 2);
        idle_cycles(2);
        // abort 5 cycles into measure with 1 error/cycle -> 5, no done
        run_test(20, 100, S + 5, 1'b0, 1, 1);
        idle_cycles(1);
        // start pulsed mid-test is ignored
        run_test(30, 500, -1, 1'b1, 0, 3);
        idle_cycles(1);

        // start and abort together in idle: stays idle, results intact
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_busy", busy, 0);
        @(posedge clk); #1;
        chk("start_abort_busy2", busy, 0);
        chk("start_abort_total", err_total, last_total);
        chk("start_abort_sat", err_sat, last_sat);
        chk("start_abort_pass", pass, last_pass);

        // window 0 behaves as 1
        run_test(0, 50, -1, 1'b0, 40, 40);
        idle_cycles(1);
        run_test(0, 10, -1, 1'b0, 0, 127);
        idle_cycles(1);

        // async reset during settle
        start         = 1'b1;
        window_len    = WW'(8);
        err_threshold = EW'(5);
        @(posedge clk); #1;
        start = 1'b0;
        idle_cycles(4);
        e.chk_len = 1'b0;
        e.len     = 0;
        e.done    = 1'b0;
        e.total   = 0;
        e.sat     = 1'b0;
        e.pass    = 1'b0;
        exp_q.push_back(e);
        #2 rst = 1'b1;
        #1 check_all_zero("reset_mid");
        @(posedge clk); #1;
        rst = 1'b0;
        idle_cycles(2);

        // randomized tests
        for (int t = 0; t < 24; t++) begin
            int w;
            int weff;
            int ka;
            int hi;
            w    = $urandom_range(40, 0);
            weff = (w == 0) ? 1 : w;
            hi   = $urandom_range(127, 0);
            ka   = -1;
            if ($urandom_range(3, 0) == 0) ka = $urandom_range(S + weff - 1, 0);
            run_test(w, $urandom_range(EMAX, 0), ka, $urandom_range(1, 0) == 1, 0, hi);
            idle_cycles($urandom_range(2, 0));
        end

        for (int i = 0; i < 50 && exp_q.size() > 0; i++) @(posedge clk);
        idle_cycles(2);
        if (exp_q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations never matched a test end, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
